// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-path widths and index-width helper
package mem_pkg;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 64;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/single_port_ram_sync.sv
// single_port_ram_sync: write-first single-port RAM with registered read data
module single_port_ram_sync
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q
);
    localparam int IDX_W = idx_w(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};
    logic [IDX_W-1:0]      idx;
    logic                  unused_addr;

    // upper address bits alias onto the same words
    assign idx         = addr[IDX_W-1:0];
    assign unused_addr = ^addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            if (we) mem[idx] <= data;
            q <= we ? data : mem[idx];
        end
    end
endmodule

// File: tb/tb_single_port_ram_sync.sv
// tb_single_port_ram_sync: directed plus random checks against an array model
module tb_single_port_ram_sync;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [31:0] q;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q;
    int          errors = 0;
    int          checks = 0;

    single_port_ram_sync dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .addr (addr),
        .data (data),
        .q    (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: apply inputs, advance model, compare q just after the edge
    task automatic op(input string tag, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rst_n = r;
        we    = w;
        addr  = a;
        data  = d;
        @(posedge clk);
        #1;
        if (!r) begin
            exp_q = '0;
        end else begin
            if (w) model[a % DEPTH] = d;
            exp_q = model[a % DEPTH];
        end
        check(tag, q, exp_q);
    endtask

    logic [31:0] waddr [6] = '{32'd1, 32'd4, 32'd8, 32'd16, 32'd20, 32'd24};
    logic [31:0] wdata [6] = '{32'hFFFFFFFF, 32'h12345678, 32'h98761234,
                               32'hA0A0A0A0, 32'hABCDEF12, 32'h00000000};

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_q = '0;
        op("reset_0", 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF);
        op("reset_1", 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF);
        op("rd_after_reset", 1'b1, 1'b0, 32'd1, 32'h0);
        check("suppressed_write", q, 32'h0);
        op("powerup_30", 1'b1, 1'b0, 32'd30, 32'h0);
        for (int i = 0; i < 6; i++) op("write_first", 1'b1, 1'b1, waddr[i], wdata[i]);
        for (int i = 0; i < 6; i++) op("readback", 1'b1, 1'b0, waddr[i], 32'h0);
        op("lat_4", 1'b1, 1'b0, 32'd4, 32'h0);
        check("lat_4_val", q, 32'h12345678);
        op("lat_8", 1'b1, 1'b0, 32'd8, 32'h0);
        check("lat_8_val", q, 32'h98761234);
        op("wrap_wr70", 1'b1, 1'b1, 32'd70, 32'hCAFEBABE);
        op("wrap_rd6", 1'b1, 1'b0, 32'd6, 32'h0);
        check("wrap_rd6_val", q, 32'hCAFEBABE);
        op("alias_65", 1'b1, 1'b0, 32'd65, 32'h0);
        check("alias_65_val", q, 32'hFFFFFFFF);
        op("mid_reset", 1'b0, 1'b0, 32'd16, 32'h0);
        op("retain_16", 1'b1, 1'b0, 32'd16, 32'h0);
        check("retain_16_val", q, 32'hA0A0A0A0);
        for (int i = 0; i < 400; i++) begin
            op("random",
               ($urandom_range(0, 19) != 0),
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 15)),
               $urandom());
        end
        for (int i = 0; i < DEPTH; i++) op("sweep", 1'b1, 1'b0, 32'(i) + 32'(DEPTH * $urandom_range(0, 3)), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
